// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - ALU writeback FIFO draining results into the register-file write port
// Optional feature macro: ALU_WB_FORWARD_EN (forwarding lookup on pending entries)
module alu_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic [AW-1:0]            in_rd,
    input  logic [3:0]               in_op,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [31:0]              wb_data,
    output logic [AW-1:0]            wb_rd,
    output logic                     zero_flag,
    output logic                     neg_flag,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_WB_FORWARD_EN
    ,
    input  logic [AW-1:0]            fwd_rd,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]     r_data [DEPTH];
    logic [AW-1:0]   r_rd   [DEPTH];
    logic [3:0]      r_unused_op [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            r_init;
    logic            r_zero;
    logic            r_neg;
    logic [CNT_W-1:0] r_retire;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;
    logic [31:0]     w_head_data;
    logic [AW-1:0]   w_head_rd;

    // r_init holds in_ready low until the first edge after reset release
    assign in_ready    = r_init && (r_count < (PW+1)'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_nonempty  = (r_count != '0);
    assign w_head_data = r_data[r_rd_ptr];
    assign w_head_rd   = r_rd[r_rd_ptr];
    // rd==0 entries retire silently without a register-file handshake
    assign w_pop       = w_nonempty && ((w_head_rd == '0) || wb_ready);

    assign wb_valid    = w_nonempty && (w_head_rd != '0);
    assign wb_data     = wb_valid ? w_head_data : '0;
    assign wb_rd       = wb_valid ? w_head_rd : '0;
    assign zero_flag   = r_zero;
    assign neg_flag    = r_neg;
    assign retire_cnt  = r_retire;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr]      <= in_result;
            r_rd[r_wr_ptr]        <= in_rd;
            r_unused_op[r_wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_init   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_retire <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_zero   <= (w_head_data == 32'd0);
                r_neg    <= w_head_data[31];
                r_retire <= r_retire + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef ALU_WB_FORWARD_EN
    // Scan oldest to youngest so the last match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < r_count) && (fwd_rd != '0) &&
                (r_rd[r_rd_ptr + PW'(i)] == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[r_rd_ptr + PW'(i)];
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - directed self-checking bench for alu_wb_buffer
module tb_alu_wb_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic [4:0]  in_rd = '0;
    logic [3:0]  in_op = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        zero_flag;
    logic        neg_flag;
    logic [15:0] retire_cnt;
    logic [2:0]  count;
`ifdef ALU_WB_FORWARD_EN
    logic [4:0]  fwd_rd = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int failures = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    alu_wb_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_rd(in_rd), .in_op(in_op),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .zero_flag(zero_flag), .neg_flag(neg_flag), .retire_cnt(retire_cnt), .count(count)
`ifdef ALU_WB_FORWARD_EN
        , .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    task automatic push_one(input logic [31:0] d, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_result = d;
        in_rd     = rd;
        in_op     = d[3:0];
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin
            failures++; $display("FAIL rst_wb got=%b/%h/%0d exp=0/0/0", wb_valid, wb_data, wb_rd); end
        checks++; if (zero_flag !== 1'b0 || neg_flag !== 1'b0 || retire_cnt !== 16'd0) begin
            failures++; $display("FAIL rst_status got=%b/%b/%0d exp=0/0/0", zero_flag, neg_flag, retire_cnt); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rel_in_ready_pre got=%b exp=0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        wb_ready = 1'b1;
        push_one(32'h0000_0005, 5'd3);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd5 || wb_rd !== 5'd3) begin
            failures++; $display("FAIL single_wb got=%b/%h/%0d exp=1/5/3", wb_valid, wb_data, wb_rd); end
        @(negedge clk);
        exp_ret += 1;
        checks++; if (zero_flag !== 1'b0 || neg_flag !== 1'b0) begin
            failures++; $display("FAIL single_flags got=%b/%b exp=0/0", zero_flag, neg_flag); end
        checks++; if (retire_cnt !== 16'(exp_ret)) begin
            failures++; $display("FAIL single_retire got=%0d exp=%0d", retire_cnt, exp_ret); end
        checks++; if (wb_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL single_empty got=%b/%0d exp=0/0", wb_valid, count); end
        wb_ready = 1'b0;
    endtask

    task automatic test_full();
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h100 + i, 5'(1 + i));
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_state got=%0d/%b exp=4/0", count, in_ready); end
        push_one(32'hDEAD, 5'd20);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_ignore got=%0d exp=4", count); end
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h100 || wb_rd !== 5'd1) begin
            failures++; $display("FAIL full_stall got=%b/%h/%0d exp=1/100/1", wb_valid, wb_data, wb_rd); end
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h100 + i || wb_rd !== 5'(1 + i)) begin
                failures++; $display("FAIL full_drain%0d got=%b/%h/%0d exp=1/%h/%0d", i, wb_valid, wb_data, wb_rd, 32'h100 + i, 1 + i); end
            @(negedge clk);
        end
        exp_ret += 4;
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) begin
            failures++; $display("FAIL full_after got=%0d/%b exp=0/0", count, wb_valid); end
        checks++; if (retire_cnt !== 16'(exp_ret)) begin
            failures++; $display("FAIL full_retire got=%0d exp=%0d", retire_cnt, exp_ret); end
        wb_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] nxt;
        int cnt;
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_one(32'h200 + i, 5'(10 + i));
            q.push_back(32'h200 + i);
        end
        cnt = 4;
        nxt = 32'h300;
        in_valid = 1'b1;
        in_rd = 5'd21;
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_result = nxt;
            checks++; if (in_ready !== (cnt < 4)) begin
                failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, in_ready, cnt < 4); end
            checks++; if (wb_valid !== 1'b1 || wb_data !== q[0]) begin
                failures++; $display("FAIL b2b_data%0d got=%b/%h exp=1/%h", i, wb_valid, wb_data, q[0]); end
            void'(q.pop_front());
            exp_ret += 1;
            if (cnt < 4) begin
                q.push_back(nxt);
                nxt = nxt + 1;
            end else begin
                cnt = cnt - 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        while (q.size() > 0) begin
            checks++; if (wb_valid !== 1'b1 || wb_data !== q[0]) begin
                failures++; $display("FAIL b2b_tail got=%b/%h exp=1/%h", wb_valid, wb_data, q[0]); end
            void'(q.pop_front());
            exp_ret += 1;
            @(negedge clk);
        end
        checks++; if (count !== 3'd0 || retire_cnt !== 16'(exp_ret)) begin
            failures++; $display("FAIL b2b_end got=%0d/%0d exp=0/%0d", count, retire_cnt, exp_ret); end
        wb_ready = 1'b0;
    endtask

    task automatic test_discard();
        wb_ready = 1'b1;
        push_one(32'hFFFF_FFFF, 5'd0);
        checks++; if (wb_valid !== 1'b0 || count !== 3'd1) begin
            failures++; $display("FAIL disc_hidden got=%b/%0d exp=0/1", wb_valid, count); end
        push_one(32'h0000_0000, 5'd7);
        exp_ret += 1;
        checks++; if (neg_flag !== 1'b1 || zero_flag !== 1'b0) begin
            failures++; $display("FAIL disc_flags got=%b/%b exp=n1/z0", neg_flag, zero_flag); end
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'd0) begin
            failures++; $display("FAIL disc_next got=%b/%0d/%h exp=1/7/0", wb_valid, wb_rd, wb_data); end
        @(negedge clk);
        exp_ret += 1;
        checks++; if (zero_flag !== 1'b1 || neg_flag !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL disc_zero got=%b/%b/%0d exp=1/0/0", zero_flag, neg_flag, count); end
        checks++; if (retire_cnt !== 16'(exp_ret)) begin
            failures++; $display("FAIL disc_retire got=%0d exp=%0d", retire_cnt, exp_ret); end
        wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(32'h8000_0040 + i, 5'(5 + i));
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_pending got=%0d exp=3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin
            failures++; $display("FAIL mid_rst_wb got=%0d/%b/%h/%0d exp=0/0/0/0", count, wb_valid, wb_data, wb_rd); end
        checks++; if (in_ready !== 1'b0 || zero_flag !== 1'b0 || neg_flag !== 1'b0 || retire_cnt !== 16'd0) begin
            failures++; $display("FAIL mid_rst_status got=%b/%b/%b/%0d exp=0/0/0/0", in_ready, zero_flag, neg_flag, retire_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wb_valid !== 1'b0 || count !== 3'd0 || retire_cnt !== 16'd0) begin
                failures++; $display("FAIL mid_after%0d got=%b/%0d/%0d exp=0/0/0", i, wb_valid, count, retire_cnt); end
        end
        wb_ready = 1'b0;
    endtask

`ifdef ALU_WB_FORWARD_EN
    task automatic test_forward();
        wb_ready = 1'b0;
        push_one(32'h33, 5'd4);
        push_one(32'h11, 5'd9);
        push_one(32'h22, 5'd9);
        fwd_rd = 5'd9;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
            failures++; $display("FAIL fwd_young got=%b/%h exp=1/22", fwd_hit, fwd_data); end
        fwd_rd = 5'd4;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h33) begin
            failures++; $display("FAIL fwd_old got=%b/%h exp=1/33", fwd_hit, fwd_data); end
        fwd_rd = 5'd0;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            failures++; $display("FAIL fwd_zero got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        fwd_rd = 5'd5;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            failures++; $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_discard();
        test_reset_mid();
`ifdef ALU_WB_FORWARD_EN
        test_forward();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
Writeback stage directly downstream of the 32-bit ALU. It captures each ALU result with its destination register and op select into a small FIFO. It drains the FIFO into the register-file write port over a valid/ready handshake, so a stalled register file never drops a result. It keeps zero/negative status flags and a retired-result counter, both updated when an entry retires.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2
AW, 5, register address width
CNT_W, 16, width of the retired-result counter

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU result presented
in_ready  output  1  buffer can accept an entry this cycle
in_result  input  32  ALU output c
in_rd  input  AW  destination register
in_op  input  4  ALU select {s3,s2,s1,s0}; stored for debug only
wb_valid  output  1  head entry is being offered to the register file
wb_ready  input  1  register file accepts the write
wb_data  output  32  head result
wb_rd  output  AW  head destination (never 0 while wb_valid=1)
zero_flag  output  1  last retired result == 0
neg_flag  output  1  last retired result bit 31
retire_cnt  output  CNT_W  number of retired entries, wraps
count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO empty, read/write pointers 0, count=0, zero_flag=0, neg_flag=0, retire_cnt=0, wb_valid=0, wb_data=0, wb_rd=0. in_ready=0 while rst_n=0, then 1 from the first edge after release.
- in_ready = (count < DEPTH). It is registered-state only and has no combinational dependence on wb_ready.
- Push: in_valid & in_ready at a rising edge writes {in_result,in_rd,in_op} at the write pointer. The write pointer increments modulo DEPTH.
- Head presentation: wb_valid, wb_data and wb_rd are driven combinationally from the head entry when count>0 and head rd!=0.
  - Minimum latency from push to wb_valid is 1 cycle; there is no fall-through in the push cycle.
- Pop: occurs at an edge when count>0 and either (head rd!=0 & wb_ready) or (head rd==0). Entries with rd==0 are discarded: they retire in one cycle without asserting wb_valid.
- Retire (every pop):
  - zero_flag <= (head result==0)
  - neg_flag <= head result[31]
  - retire_cnt <= retire_cnt+1, wrapping from 2^CNT_W-1 to 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, in_ready=0, so only the pop occurs; in_ready is 1 on the next cycle.
  - When empty, only the push occurs.
- wb_data and wb_rd remain stable while wb_valid=1 and wb_ready=0.
- Pointers wrap modulo DEPTH. Full = count==DEPTH; empty = count==0.
- Reset asserted mid-operation: all pending entries are discarded immediately and not written back. Outputs return to reset values asynchronously.

Optional Feature:
Macro ALU_WB_FORWARD_EN.
- Defined: extra ports fwd_rd (input AW), fwd_hit (output 1) and fwd_data (output 32).
  - fwd_hit=1 when any pending entry has rd==fwd_rd and fwd_rd!=0.
  - fwd_data is the result of the youngest such entry; it is 0 when there is no hit.
  - Both outputs are purely combinational from the FIFO contents and fwd_rd.
- Undefined: these ports do not exist and no compare logic is built.

Test Plan:
- Reset release, push {0x0000_0005, rd=3}, wb_ready=1 -> wb_valid=1 next cycle with wb_data=5 and wb_rd=3. It retires that cycle: zero_flag=0, neg_flag=0, retire_cnt=1.
- Hold wb_ready=0 and push 4 entries (DEPTH=4) -> count=4 and in_ready=0. A 5th in_valid is ignored. Raise wb_ready -> 4 writes in push order on consecutive cycles, then count=0.
- Full FIFO, in_valid=1 and wb_ready=1 continuously -> one pop per cycle. A new push is accepted on each cycle that follows a cycle in which count<4, and no entry is lost or duplicated.
- Push {0xFFFF_FFFF, rd=0} then {0x0000_0000, rd=7} -> the rd=0 entry retires without wb_valid. The next entry writes rd=7; after it retires zero_flag=1 and neg_flag=0.
- Pulse rst_n low with 3 entries pending and wb_ready=0 -> count=0, wb_valid=0 and all outputs at reset values immediately. No writes occur after release.
- With ALU_WB_FORWARD_EN defined: pending rd=9 entries 0x11 then 0x22, fwd_rd=9 -> fwd_hit=1, fwd_data=0x22. With fwd_rd=0 -> fwd_hit=0, fwd_data=0.
